// File: rtl/metrics_window_ctrl_if.sv
// Bus between the control register bank (master) and the metrics window sequencer (slave).
// The irq line exists only when CTRL_WINDOW_IRQ_EN is defined.
interface metrics_window_ctrl_if #(
  parameter int TIMEOUT_WIDTH = 32,
  parameter int WIN_CNT_WIDTH = 16
);
  logic                     cfg_valid;
  logic [7:0]               cfg_data;
  logic [TIMEOUT_WIDTH-1:0] timeout_limit;
  logic                     start_evt;
  logic                     stop_evt;
  logic                     cnt_en;
  logic                     cnt_clear;
  logic                     busy;
  logic                     done;
  logic                     timeout;
  logic [WIN_CNT_WIDTH-1:0] win_count;
  logic [1:0]               state_o;
`ifdef CTRL_WINDOW_IRQ_EN
  logic                     irq;
`endif

  modport master (
    output cfg_valid, cfg_data, timeout_limit, start_evt, stop_evt,
    input  cnt_en, cnt_clear, busy, done, timeout, win_count, state_o
`ifdef CTRL_WINDOW_IRQ_EN
    , input irq
`endif
  );

  modport slave (
    input  cfg_valid, cfg_data, timeout_limit, start_evt, stop_evt,
    output cnt_en, cnt_clear, busy, done, timeout, win_count, state_o
`ifdef CTRL_WINDOW_IRQ_EN
    , output irq
`endif
  );
endinterface

// File: rtl/metrics_window_ctrl.sv
// Measurement window sequencer: turns command bytes into metrics counter enable/clear strobes.
// Optional window-done interrupt is built when CTRL_WINDOW_IRQ_EN is defined.
module metrics_window_ctrl #(
  parameter int TIMEOUT_WIDTH = 32,
  parameter int WIN_CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  metrics_window_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_trig, r_cont, w_trig_nxt, w_cont_nxt;
  logic [TIMEOUT_WIDTH-1:0] r_wd, w_wd_nxt, w_wd_inc;
  logic [WIN_CNT_WIDTH-1:0] r_win, w_win_nxt, w_win_inc;
  logic                     r_done, w_done_nxt, r_to, w_to_nxt;
  logic                     r_cnt_en, r_cnt_clear, r_busy;
  logic                     w_go, w_clr, w_abort, w_expire;
  logic                     w_unused;

  assign w_go     = bus.cfg_valid & bus.cfg_data[0];
  assign w_clr    = bus.cfg_valid & bus.cfg_data[1];
  assign w_abort  = bus.cfg_valid & bus.cfg_data[4];
  assign w_wd_inc = r_wd + TIMEOUT_WIDTH'(1);
  // A limit at or below the current count only matches again after the counter wraps.
  assign w_expire  = (bus.timeout_limit != '0) && (w_wd_inc == bus.timeout_limit);
  assign w_win_inc = (&r_win) ? r_win : (r_win + WIN_CNT_WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_trig_nxt  = r_trig;
    w_cont_nxt  = r_cont;
    w_wd_nxt    = r_wd;
    w_win_nxt   = r_win;
    w_done_nxt  = r_done;
    w_to_nxt    = r_to;
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_wd_nxt    = '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_go) begin
            w_trig_nxt  = bus.cfg_data[2];
            w_cont_nxt  = bus.cfg_data[3];
            w_wd_nxt    = '0;
            w_done_nxt  = 1'b0;
            w_to_nxt    = 1'b0;
            w_state_nxt = bus.cfg_data[2] ? ARMED : RUN;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ARMED: begin
          if (bus.start_evt) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = ARMED;
          end
        end
        RUN: begin
          // stop outranks a simultaneous watchdog expiry
          if (bus.stop_evt) begin
            w_win_nxt = w_win_inc;
            w_wd_nxt  = '0;
            if (r_cont && r_trig) begin
              w_state_nxt = ARMED;
            end else begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end
          end else if (w_expire) begin
            w_win_nxt   = w_win_inc;
            w_wd_nxt    = '0;
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_to_nxt    = 1'b1;
          end else begin
            w_wd_nxt = w_wd_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, sticky flags and registered counter strobes; clear overrides the window result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_trig      <= 1'b0;
      r_cont      <= 1'b0;
      r_wd        <= '0;
      r_win       <= '0;
      r_done      <= 1'b0;
      r_to        <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_cnt_clear <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_trig      <= w_trig_nxt;
      r_cont      <= w_cont_nxt;
      r_wd        <= w_wd_nxt;
      r_win       <= w_clr ? '0 : w_win_nxt;
      r_done      <= w_clr ? 1'b0 : w_done_nxt;
      r_to        <= w_clr ? 1'b0 : w_to_nxt;
      r_cnt_en    <= (w_state_nxt == RUN);
      r_cnt_clear <= w_clr;
      r_busy      <= (w_state_nxt == ARMED) || (w_state_nxt == RUN);
    end
  end

`ifdef CTRL_WINDOW_IRQ_EN
  logic r_irq;
  logic w_irq_set, w_irq_clr;

  assign w_irq_set = (w_state_nxt == DONE) && (r_state != DONE);
  assign w_irq_clr = bus.cfg_valid & (bus.cfg_data[5] | bus.cfg_data[1]);

  // Interrupt latch; a new DONE entry beats a same-cycle acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (w_irq_clr) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq;
    end
  end

  assign bus.irq  = r_irq;
  assign w_unused = ^bus.cfg_data[7:6];
`else
  assign w_unused = ^bus.cfg_data[7:5];
`endif

  assign bus.cnt_en    = r_cnt_en;
  assign bus.cnt_clear = r_cnt_clear;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.timeout   = r_to;
  assign bus.win_count = r_win;
  assign bus.state_o   = r_state;
endmodule
